jk_bank_arbiter: RTL
====================

Name: jk_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit bank of enable-gated JK storage cells between N_REQ requesters.
- Each requester presents per-bit J/K command vectors.
- The arbiter grants one requester at a time, captures its command, and pulses the bank enable for exactly one cycle so that all bits update together. It then completes a request/grant/done handshake.
- Sits between the lab's control logic and the JK latch bank.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, number of JK bits in the shared bank.

Ports:
- cp  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  request lines; bit i = requester i.
- req_j  input  N_REQ*WIDTH  J vectors; requester i occupies bits [i*WIDTH +: WIDTH].
- req_k  input  N_REQ*WIDTH  K vectors; same packing as req_j.
- grant  output  N_REQ  one-hot grant; all-zero when idle.
- done  output  1  one-cycle pulse: the granted command has been applied.
- busy  output  1  high in every state except IDLE.
- q  output  WIDTH  bank state.
- notq  output  WIDTH  always equals ~q.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, q=0, notq=all-ones, grant=0, done=0, busy=0.
  - Round-robin pointer = 0, so requester 0 has top priority.
  - Captured command is cleared.
- States: IDLE, CAPTURE, APPLY, RELEASE.
- IDLE:
  - If req has any bit set: choose the winner, next state CAPTURE.
  - Winner search starts at the pointer and proceeds upward modulo N_REQ; first set bit wins.
  - Otherwise remain in IDLE.
- CAPTURE (1 cycle):
  - grant[winner]=1, busy=1.
  - Winner's req_j/req_k slices are registered on this edge.
  - Later changes to the winner's vectors are ignored.
  - Next state APPLY.
- APPLY (1 cycle):
  - Internal enable is high.
  - On the exit edge each bit n updates from captured (j,k): 00 hold, 01 q=0, 10 q=1, 11 q=~q.
  - Next state RELEASE.
- RELEASE:
  - done=1 only in the first RELEASE cycle. New q is visible in that same cycle.
  - grant stays asserted while req[winner]=1.
  - When req[winner]=0: grant drops, pointer = (winner+1) mod N_REQ, next state IDLE.
- Latency: req sampled in IDLE at edge 0 → grant visible after edge 0 → q updated and done visible after edge 2. This gives at least 4 cycles per transaction, including one IDLE cycle.
- q changes only on the APPLY exit edge, never otherwise.
- Requests arriving mid-transaction wait for arbitration. Requests from non-granted requesters are never lost while they are held.
- A requester dropping req before done does not abort the transaction. The command completes, and RELEASE exits on the first cycle req[winner]=0, after done.
- Simultaneous requests: resolved purely by the round-robin order. No requester can be granted twice in a row while another holds req.
- Reset asserted in CAPTURE or APPLY: q is forced to 0 and the pending command is discarded. done is never produced for that command.
- grant is always one-hot or zero. Assertion: popcount(grant) ≤ 1.

Test Plan:
- Reset then idle: rst=1 → q=4'b0000, notq=4'b1111, grant=0, busy=0. Release rst with req=0 for 5 cycles → no change.
- Single request: req=4'b0001, j=4'b1010, k=4'b0000 → grant=4'b0001 one cycle later, q=4'b1010 with done pulse two cycles after grant. Drop req → grant=0, busy=0 next cycle.
- Full JK truth table, starting q=4'b1010: j=4'b0011, k=4'b0101 (bits: toggle, set, reset, hold) → q=4'b1011.
- Round-robin fairness: req=4'b1111 held for every transaction, each requester dropping req after its done → grant order 0,1,2,3,0. Each requester's command appears on q in that order.
- Command stability: change the winner's req_j during APPLY → q reflects the value captured in CAPTURE, not the new one.
- Reset mid-operation: assert rst during APPLY with j=4'b1111 → q=4'b0000, no done pulse. After release, the next request is granted starting from requester 0.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that shares one enable-gated JK storage bank between N_REQ requesters.
// Each transaction is grant -> capture -> one-cycle apply -> release/done handshake.
module jk_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                   cp,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_j,
    input  logic [N_REQ*WIDTH-1:0] req_k,
    output logic [N_REQ-1:0]       grant,
    output logic                   done,
    output logic                   busy,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       notq
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        APPLY   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_winner;
    logic [WIDTH-1:0]  r_capJ;
    logic [WIDTH-1:0]  r_capK;
    logic [WIDTH-1:0]  r_q;
    logic              r_donePend;

    logic [2*N_REQ-1:0] w_reqDbl;
    logic [N_REQ-1:0]   w_reqRot;
    logic [PW-1:0]      w_offset;
    logic [PW:0]        w_sum;
    logic [PW-1:0]      w_winner;
    logic [PW-1:0]      w_ptrNext;

    // Rotate req so bit 0 is the pointer position; the lowest set bit is the winner's offset.
    always_comb begin
        w_reqDbl = {req, req};
        w_reqRot = N_REQ'(w_reqDbl >> r_ptr);
        w_offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_reqRot[i]) begin
                w_offset = PW'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_offset};
        if (w_sum >= (PW+1)'(N_REQ)) begin
            w_sum = w_sum - (PW+1)'(N_REQ);
        end
        w_winner  = w_sum[PW-1:0];
        w_ptrNext = (r_winner == PW'(N_REQ - 1)) ? '0 : r_winner + 1'b1;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (|req) w_nextState = CAPTURE;
            CAPTURE: w_nextState = APPLY;
            APPLY:   w_nextState = RELEASE;
            RELEASE: if (!req[r_winner]) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_winner   <= '0;
            r_capJ     <= '0;
            r_capK     <= '0;
            r_q        <= '0;
            r_donePend <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_donePend <= (r_state == APPLY);
            if (r_state == IDLE && (|req)) begin
                r_winner <= w_winner;
            end
            if (r_state == CAPTURE) begin
                r_capJ <= req_j[int'(r_winner)*WIDTH +: WIDTH];
                r_capK <= req_k[int'(r_winner)*WIDTH +: WIDTH];
            end
            // Characteristic equation q+ = j&~q | ~k&q covers hold/reset/set/toggle.
            if (r_state == APPLY) begin
                r_q <= (r_capJ & ~r_q) | (~r_capK & r_q);
            end
            if (r_state == RELEASE && !req[r_winner]) begin
                r_ptr <= w_ptrNext;
            end
        end
    end

    assign grant = (r_state != IDLE) ? (N_REQ'(1) << r_winner) : '0;
    assign done  = r_donePend;
    assign busy  = (r_state != IDLE);
    assign q     = r_q;
    assign notq  = ~r_q;

    a_grantOneHot: assert property (@(posedge cp) disable iff (rst) $countones(grant) <= 1);

endmodule
